phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Responder side of the MD timestep phase handshake. Consumes phase1_ready / phase3_ready / double_buffer from the control unit and produces mem_set, phase1_done, phase3_done and step.
- Tracks the particle-memory initial load, broadcasts a start pulse to N compute units at each phase entry, and aggregates their completion pulses.
- Advances the timestep counter and stops after a programmed number of steps.

Parameters:
- N_UNITS, 8, number of compute units reporting per-phase completion.
- LOAD_WORDS, 64, particle-memory writes required before mem_set asserts.
- STEP_W, 32, width of step and num_steps.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run (ignored unless state is IDLE)
- num_steps  in  STEP_W  timesteps to run; latched on accepted start
- load_we  in  1  one-cycle strobe per particle-memory word written by the loader
- phase1_ready  in  1  control unit is in force phase
- phase3_ready  in  1  control unit is in motion-update phase
- double_buffer  in  1  control unit's current buffer select
- p1_unit_done  in  N_UNITS  per-unit one-cycle completion pulses, phase 1
- p3_unit_done  in  N_UNITS  per-unit one-cycle completion pulses, phase 3
- mem_set  out  1  particle memory loaded; sticky until reset
- phase1_done  out  1  all units finished phase 1; level, held until handoff
- phase3_done  out  1  all units finished phase 3; level, held until handoff
- step  out  STEP_W  completed timesteps
- unit_start  out  1  one-cycle pulse to all units at phase entry
- unit_phase  out  1  0 = phase 1, 1 = phase 3; valid from unit_start onward
- buffer_sel  out  1  double_buffer value sampled on the unit_start cycle
- busy  out  1  high in every state except IDLE and DONE
- sim_done  out  1  run complete; sticky until reset
- error  out  1  sticky protocol-violation flag

Behaviour:
- Reset: state=IDLE. All outputs, load_cnt, done mask and latched num_steps are 0. Reset mid-run aborts immediately with no outputs held over.
- Registers: all outputs are registered. unit_start is high for exactly one cycle.
- IDLE:
  - On start: latch num_steps, clear load_cnt, go to LOAD, busy=1.
- LOAD:
  - Each load_we increments load_cnt.
  - On the cycle of the LOAD_WORDS-th strobe: next edge mem_set=1, state goes to ARM.
  - Further load_we strobes after this point are ignored.
- ARM:
  - If latched num_steps==0: go to DONE.
  - Else, if phase1_ready: unit_start=1, unit_phase=0, buffer_sel=double_buffer, mask cleared, go to P1_RUN.
  - Else, if phase3_ready: the same actions with unit_phase=1, go to P3_RUN.
  - If both ready signals are high: error=1, treat as phase 1.
- P1_RUN / P3_RUN:
  - mask |= matching done vector every cycle.
  - Completion is mask OR the current-cycle pulses == all ones.
  - A repeated pulse from an already-done unit is ignored without error.
- P1_RUN completion: next edge phase1_done=1, go to P1_WAIT.
- P3_RUN completion: on the same edge, step<=step+1 and phase3_done=1, go to P3_WAIT. step therefore changes in the same cycle phase3_done rises.
- P1_WAIT: hold phase1_done until phase1_ready==0, then deassert and go to ARM.
- P3_WAIT:
  - Hold phase3_done until phase3_ready==0, then deassert.
  - If double_buffer==buffer_sel at that cycle: error=1.
  - If step==num_steps: go to DONE, else go to ARM.
- DONE: sim_done=1, busy=0. Remain until reset.
- Protocol errors (error=1, sticky; does not alter the state machine):
  - Any bit of p1_unit_done outside P1_RUN.
  - Any bit of p3_unit_done outside P3_RUN.
  - load_we outside LOAD after mem_set.
- Arithmetic: step never wraps because the run terminates at num_steps. No minimum latency is imposed between unit_start and done pulses; a pulse in the cycle after unit_start counts.

Test Plan (N_UNITS=4, LOAD_WORDS=8):
- Load: start with num_steps=2, then 8 load_we strobes spaced 1-3 cycles. Required: mem_set rises exactly one cycle after the 8th strobe, not before; busy=1 from the cycle after start.
- Phase 3 first: CU model asserts phase3_ready after mem_set; units pulse bits 0,2 then 1,3 on separate cycles. Required: unit_start once with unit_phase=1; phase3_done and step=1 together one edge after the last pulse; phase3_done held until phase3_ready drops.
- Full run: CU model alternates phase3 -> phase1 -> phase3, toggling double_buffer. Required: step goes 1 then 2; sim_done=1, busy=0 after the second phase3 handoff; error stays 0.
- Duplicate and simultaneous pulses: in P1_RUN drive 4'b0011, then 4'b0001, then 4'b1100. Required: phase1_done asserts only after 4'b1100; error=0.
- Violations:
  - p1_unit_done=4'b0001 while in P3_RUN -> error=1.
  - double_buffer not toggled at a phase3 handoff -> error=1.
  - Both ready signals high in ARM -> error=1 and phase-1 entry.
- Reset mid-P1_RUN with mask=4'b0111. Required: next cycle all outputs 0, state IDLE; a new start with num_steps=0 loads 8 words then sets sim_done=1 without issuing unit_start.

Source files
------------

// File: rtl/phase_sequencer.sv
// rtl/phase_sequencer.sv - MD timestep phase handshake responder
//
// Purpose:
//   Answers the control unit's phase handshake for one molecular-dynamics
//   timestep loop. It waits for the particle memory to be loaded, then at every
//   phase entry pulses unit_start to all compute units. It collects their
//   per-unit completion pulses, signals phase1_done / phase3_done, and counts
//   completed timesteps until the programmed number of steps is reached.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle run request, accepted only in IDLE
//   num_steps       timesteps to run, captured when start is accepted
//   load_we         one strobe per particle-memory word written
//   phase1_ready    control unit is in the force phase
//   phase3_ready    control unit is in the motion-update phase
//   double_buffer   control unit's current buffer select
//   p1_unit_done    per-unit completion pulses for phase 1
//   p3_unit_done    per-unit completion pulses for phase 3
//   mem_set         particle memory loaded (sticky)
//   phase1_done     all units finished phase 1 (level until handoff)
//   phase3_done     all units finished phase 3 (level until handoff)
//   step            completed timesteps
//   unit_start      one-cycle start pulse to every compute unit
//   unit_phase      0 = phase 1, 1 = phase 3
//   buffer_sel      double_buffer captured at phase entry
//   busy            run in progress (not IDLE, not DONE)
//   sim_done        run complete (sticky)
//   error           sticky protocol-violation flag

module phase_sequencer #(
    parameter int N_UNITS    = 8,
    parameter int LOAD_WORDS = 64,
    parameter int STEP_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic               load_we,
    input  logic               phase1_ready,
    input  logic               phase3_ready,
    input  logic               double_buffer,
    input  logic [N_UNITS-1:0] p1_unit_done,
    input  logic [N_UNITS-1:0] p3_unit_done,
    output logic               mem_set,
    output logic               phase1_done,
    output logic               phase3_done,
    output logic [STEP_W-1:0]  step,
    output logic               unit_start,
    output logic               unit_phase,
    output logic               buffer_sel,
    output logic               busy,
    output logic               sim_done,
    output logic               error
);

    localparam int LOAD_CNT_W = (LOAD_WORDS < 2) ? 1 : $clog2(LOAD_WORDS + 1);
    localparam logic [LOAD_CNT_W-1:0] LAST_WORD = LOAD_CNT_W'(LOAD_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ARM,
        S_P1_RUN,
        S_P3_RUN,
        S_P1_WAIT,
        S_P3_WAIT,
        S_DONE
    } state_t;

    state_t                state;
    logic [LOAD_CNT_W-1:0] load_cnt;
    logic [N_UNITS-1:0]    mask;
    logic [STEP_W-1:0]     num_steps_q;

    // Units already recorded plus the ones reporting this cycle; a pulse that
    // arrives on the completing cycle must count without waiting for the mask.
    logic [N_UNITS-1:0] p1_seen;
    logic [N_UNITS-1:0] p3_seen;
    logic               p1_all;
    logic               p3_all;
    logic               violation;

    assign p1_seen = mask | p1_unit_done;
    assign p3_seen = mask | p3_unit_done;
    assign p1_all  = &p1_seen;
    assign p3_all  = &p3_seen;

    // Violations that do not depend on the state transition being taken.
    // mem_set is only ever high outside LOAD, so a load strobe while it is
    // set is by construction a strobe after the memory was declared full.
    always_comb begin
        violation = 1'b0;
        if ((|p1_unit_done) && (state != S_P1_RUN)) begin
            violation = 1'b1;
        end
        if ((|p3_unit_done) && (state != S_P3_RUN)) begin
            violation = 1'b1;
        end
        if (load_we && mem_set) begin
            violation = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            load_cnt    <= '0;
            mask        <= '0;
            num_steps_q <= '0;
            mem_set     <= 1'b0;
            phase1_done <= 1'b0;
            phase3_done <= 1'b0;
            step        <= '0;
            unit_start  <= 1'b0;
            unit_phase  <= 1'b0;
            buffer_sel  <= 1'b0;
            busy        <= 1'b0;
            sim_done    <= 1'b0;
            error       <= 1'b0;
        end else begin
            unit_start <= 1'b0;
            if (violation) begin
                error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        num_steps_q <= num_steps;
                        load_cnt    <= '0;
                        busy        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    if (load_we) begin
                        load_cnt <= load_cnt + LOAD_CNT_W'(1);
                        if (load_cnt == LAST_WORD) begin
                            mem_set <= 1'b1;
                            state   <= S_ARM;
                        end
                    end
                end

                S_ARM: begin
                    if (num_steps_q == '0) begin
                        sim_done <= 1'b1;
                        busy     <= 1'b0;
                        state    <= S_DONE;
                    end else if (phase1_ready || phase3_ready) begin
                        unit_start <= 1'b1;
                        buffer_sel <= double_buffer;
                        mask       <= '0;
                        if (phase1_ready) begin
                            // Both ready at once is ambiguous; phase 1 wins
                            // and the conflict is flagged.
                            unit_phase <= 1'b0;
                            state      <= S_P1_RUN;
                            if (phase3_ready) begin
                                error <= 1'b1;
                            end
                        end else begin
                            unit_phase <= 1'b1;
                            state      <= S_P3_RUN;
                        end
                    end
                end

                S_P1_RUN: begin
                    mask <= p1_seen;
                    if (p1_all) begin
                        phase1_done <= 1'b1;
                        state       <= S_P1_WAIT;
                    end
                end

                S_P3_RUN: begin
                    mask <= p3_seen;
                    if (p3_all) begin
                        // The step count moves together with phase3_done so
                        // the control unit sees a consistent pair.
                        step        <= step + STEP_W'(1);
                        phase3_done <= 1'b1;
                        state       <= S_P3_WAIT;
                    end
                end

                S_P1_WAIT: begin
                    if (!phase1_ready) begin
                        phase1_done <= 1'b0;
                        state       <= S_ARM;
                    end
                end

                S_P3_WAIT: begin
                    if (!phase3_ready) begin
                        phase3_done <= 1'b0;
                        // The control unit must swap buffers at every motion
                        // update; an unchanged select means stale positions.
                        if (double_buffer == buffer_sel) begin
                            error <= 1'b1;
                        end
                        if (step == num_steps_q) begin
                            sim_done <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_DONE;
                        end else begin
                            state <= S_ARM;
                        end
                    end
                end

                S_DONE: begin
                    // Terminal until reset.
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb/tb_phase_sequencer.sv - directed self-checking bench for phase_sequencer

module tb_phase_sequencer;

    localparam int NU = 4;
    localparam int LW = 8;
    localparam int SW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [SW-1:0] num_steps;
    logic          load_we;
    logic          phase1_ready;
    logic          phase3_ready;
    logic          double_buffer;
    logic [NU-1:0] p1_unit_done;
    logic [NU-1:0] p3_unit_done;
    logic          mem_set;
    logic          phase1_done;
    logic          phase3_done;
    logic [SW-1:0] step;
    logic          unit_start;
    logic          unit_phase;
    logic          buffer_sel;
    logic          busy;
    logic          sim_done;
    logic          error;

    phase_sequencer #(
        .N_UNITS    (NU),
        .LOAD_WORDS (LW),
        .STEP_W     (SW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_steps     (num_steps),
        .load_we       (load_we),
        .phase1_ready  (phase1_ready),
        .phase3_ready  (phase3_ready),
        .double_buffer (double_buffer),
        .p1_unit_done  (p1_unit_done),
        .p3_unit_done  (p3_unit_done),
        .mem_set       (mem_set),
        .phase1_done   (phase1_done),
        .phase3_done   (phase3_done),
        .step          (step),
        .unit_start    (unit_start),
        .unit_phase    (unit_phase),
        .buffer_sel    (buffer_sel),
        .busy          (busy),
        .sim_done      (sim_done),
        .error         (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Expected outputs, updated by the scenario tasks from the handshake rules.
    logic          e_mem_set = 1'b0;
    logic          e_phase1_done = 1'b0;
    logic          e_phase3_done = 1'b0;
    logic [SW-1:0] e_step = '0;
    logic          e_unit_start = 1'b0;
    logic          e_unit_phase = 1'b0;
    logic          e_buffer_sel = 1'b0;
    logic          e_busy = 1'b0;
    logic          e_sim_done = 1'b0;
    logic          e_error = 1'b0;

    // Run bookkeeping: requested steps, words loaded, which phase the units
    // are working on (0 none, 1 phase 1, 3 phase 3), which phase awaits handoff.
    int            m_num = 0;
    int            m_loads = 0;
    int            m_run = 0;
    int            m_wait = 0;
    logic [NU-1:0] m_mask = '0;

    int gaps [LW] = '{0, 1, 2, 0, 2, 1, 0, 1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("mem_set",     32'(mem_set),     32'(e_mem_set));
            check("phase1_done", 32'(phase1_done), 32'(e_phase1_done));
            check("phase3_done", 32'(phase3_done), 32'(e_phase3_done));
            check("step",        step,             e_step);
            check("unit_start",  32'(unit_start),  32'(e_unit_start));
            check("unit_phase",  32'(unit_phase),  32'(e_unit_phase));
            check("buffer_sel",  32'(buffer_sel),  32'(e_buffer_sel));
            check("busy",        32'(busy),        32'(e_busy));
            check("sim_done",    32'(sim_done),    32'(e_sim_done));
            check("error",       32'(error),       32'(e_error));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        e_unit_start = 1'b0;
    endtask

    task automatic hold(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        start = 1'b0;
        load_we = 1'b0;
        phase1_ready = 1'b0;
        phase3_ready = 1'b0;
        double_buffer = 1'b0;
        p1_unit_done = '0;
        p3_unit_done = '0;
        num_steps = '0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        e_mem_set = 1'b0;
        e_phase1_done = 1'b0;
        e_phase3_done = 1'b0;
        e_step = '0;
        e_unit_phase = 1'b0;
        e_buffer_sel = 1'b0;
        e_busy = 1'b0;
        e_sim_done = 1'b0;
        e_error = 1'b0;
        m_num = 0;
        m_loads = 0;
        m_run = 0;
        m_wait = 0;
        m_mask = '0;
    endtask

    task automatic start_run(input int n);
        num_steps = SW'(n);
        start = 1'b1;
        cyc();
        start = 1'b0;
        e_busy = 1'b1;
        m_num = n;
        m_loads = 0;
    endtask

    task automatic load_all(input bit spaced);
        for (int i = 0; i < LW; i++) begin
            if (spaced) hold(gaps[i]);
            load_we = 1'b1;
            cyc();
            load_we = 1'b0;
            m_loads++;
            if (m_loads == LW) e_mem_set = 1'b1;
        end
        // A zero-step run finishes one cycle after the memory is declared full.
        if (m_num == 0) begin
            cyc();
            e_sim_done = 1'b1;
            e_busy = 1'b0;
        end
    endtask

    task automatic enter(input bit p1r, input bit p3r, input bit db);
        phase1_ready = p1r;
        phase3_ready = p3r;
        double_buffer = db;
        cyc();
        e_unit_start = 1'b1;
        e_unit_phase = p1r ? 1'b0 : 1'b1;
        e_buffer_sel = db;
        if (p1r && p3r) e_error = 1'b1;
        m_run = p1r ? 1 : 3;
        m_mask = '0;
    endtask

    task automatic pulse(input logic [NU-1:0] v1, input logic [NU-1:0] v3);
        logic [NU-1:0] v;
        p1_unit_done = v1;
        p3_unit_done = v3;
        cyc();
        p1_unit_done = '0;
        p3_unit_done = '0;
        if (v1 != '0 && m_run != 1) e_error = 1'b1;
        if (v3 != '0 && m_run != 3) e_error = 1'b1;
        v = (m_run == 1) ? v1 : (m_run == 3) ? v3 : '0;
        m_mask = m_mask | v;
        if (m_run != 0 && m_mask == '1) begin
            if (m_run == 3) begin
                e_phase3_done = 1'b1;
                e_step = e_step + 1;
            end else begin
                e_phase1_done = 1'b1;
            end
            m_wait = m_run;
            m_run = 0;
        end
    endtask

    task automatic handoff(input bit db);
        phase1_ready = 1'b0;
        phase3_ready = 1'b0;
        double_buffer = db;
        cyc();
        if (m_wait == 1) begin
            e_phase1_done = 1'b0;
        end else if (m_wait == 3) begin
            e_phase3_done = 1'b0;
            if (db == e_buffer_sel) e_error = 1'b1;
            if (int'(e_step) == m_num) begin
                e_sim_done = 1'b1;
                e_busy = 1'b0;
            end
        end
        m_wait = 0;
    endtask

    task automatic stray_load();
        load_we = 1'b1;
        cyc();
        load_we = 1'b0;
        if (m_loads >= LW) e_error = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        chk_en = 1'b1;
        check("lit_reset_busy", 32'(busy), 32'd0);
        check("lit_reset_step", step, 32'd0);

        // Full run: phase 3 first, then phase 1, then phase 3, buffers toggling.
        start_run(2);
        load_all(1'b1);
        enter(1'b0, 1'b1, 1'b0);
        pulse(4'b0000, 4'b0101);
        pulse(4'b0000, 4'b1010);
        check("lit_step_after_first_p3", step, 32'd1);
        check("lit_p3done_first", 32'(phase3_done), 32'd1);
        hold(2);
        handoff(1'b1);
        enter(1'b1, 1'b0, 1'b1);
        pulse(4'b0011, 4'b0000);
        pulse(4'b0001, 4'b0000);
        check("lit_p1done_after_dup", 32'(phase1_done), 32'd0);
        pulse(4'b1100, 4'b0000);
        check("lit_p1done_after_1100", 32'(phase1_done), 32'd1);
        hold(1);
        handoff(1'b1);
        enter(1'b0, 1'b1, 1'b1);
        pulse(4'b0000, 4'b1111);
        hold(1);
        handoff(1'b0);
        check("lit_final_step", step, 32'd2);
        check("lit_final_sim_done", 32'(sim_done), 32'd1);
        check("lit_final_busy", 32'(busy), 32'd0);
        check("lit_final_error", 32'(error), 32'd0);
        hold(3);

        // Phase-1 completion pulse during phase 3.
        do_reset();
        start_run(3);
        load_all(1'b0);
        enter(1'b0, 1'b1, 1'b0);
        pulse(4'b0001, 4'b0000);
        check("lit_err_p1_in_p3", 32'(error), 32'd1);
        pulse(4'b0000, 4'b1111);
        handoff(1'b1);
        hold(1);

        // Buffer select not toggled at a phase-3 handoff.
        do_reset();
        start_run(3);
        load_all(1'b0);
        enter(1'b0, 1'b1, 1'b0);
        pulse(4'b0000, 4'b1111);
        hold(1);
        check("lit_err_before_handoff", 32'(error), 32'd0);
        handoff(1'b0);
        check("lit_err_no_toggle", 32'(error), 32'd1);
        check("lit_step_no_toggle", step, 32'd1);
        hold(1);

        // Both ready signals in ARM, then reset in the middle of phase 1.
        do_reset();
        start_run(3);
        load_all(1'b0);
        enter(1'b1, 1'b1, 1'b0);
        check("lit_err_both_ready", 32'(error), 32'd1);
        check("lit_phase_both_ready", 32'(unit_phase), 32'd0);
        pulse(4'b1111, 4'b0000);
        handoff(1'b0);
        enter(1'b1, 1'b0, 1'b0);
        pulse(4'b0011, 4'b0000);
        pulse(4'b0100, 4'b0000);
        do_reset();
        check("lit_midrun_reset_busy", 32'(busy), 32'd0);
        check("lit_midrun_reset_error", 32'(error), 32'd0);
        check("lit_midrun_reset_mem_set", 32'(mem_set), 32'd0);

        // Zero-step run: never starts the units even with phase 1 offered.
        phase1_ready = 1'b1;
        start_run(0);
        load_all(1'b1);
        hold(3);
        check("lit_zero_sim_done", 32'(sim_done), 32'd1);
        check("lit_zero_step", step, 32'd0);
        stray_load();
        check("lit_err_stray_load", 32'(error), 32'd1);
        hold(2);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
